// File: rtl/sar_search_4bit_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encodings, default trial width and the comparator response check.
package sar_search_4bit_pkg;

    // Default trial/result width; the paired comparator must match it.
    localparam int SAR_WIDTH = 4;

    // Encoding 2'd3 is unused and is decoded as IDLE by the controller.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRY  = 2'd1,
        S_DONE = 2'd2
    } sar_state_e;

    // A consistent comparator asserts exactly one of its three outputs.
    function automatic logic resp_onehot(input logic eq, input logic gt, input logic lt);
        logic ok;
        case ({eq, gt, lt})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Combinational magnitude comparator; the search controller drives b and
// converges on the value presented at a.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       equal,
    output logic       greater,
    output logic       lesser
);

    assign equal   = (a == b);
    assign greater = (a > b);
    assign lesser  = (a < b);

endmodule

// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller. Issues trial values to a
// magnitude comparator and resolves the unknown operand one bit per cycle,
// MSB first, with an early exit when the comparator reports equality.
module sar_search_4bit
    import sar_search_4bit_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_lesser,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] trial_work;
    logic             resp_ok;

    assign resp_ok = resp_onehot(cmp_equal, cmp_greater, cmp_lesser);

    // Next-state and datapath decisions; every register holds by default.
    always_comb begin
        state_d    = state_q;
        trial_d    = trial_q;
        pos_d      = pos_q;
        result_d   = result_q;
        error_d    = error_q;
        trial_work = trial_q;

        case (state_q)
            S_TRY: begin
                if (!resp_ok) begin
                    // Inconsistent comparator: abandon the search.
                    error_d  = 1'b1;
                    result_d = '0;
                    trial_d  = '0;
                    state_d  = S_DONE;
                end else if (cmp_equal) begin
                    result_d = trial_q;
                    trial_d  = '0;
                    state_d  = S_DONE;
                end else begin
                    // Target below the trial: the bit under test must be 0.
                    if (cmp_lesser) begin
                        trial_work[pos_q] = 1'b0;
                    end
                    if (pos_q != '0) begin
                        trial_work[pos_q - 1'b1] = 1'b1;
                        trial_d                  = trial_work;
                        pos_d                    = pos_q - 1'b1;
                    end else begin
                        trial_d = '0;
                        state_d = S_DONE;
                        if (cmp_lesser) begin
                            result_d = trial_work;
                        end else begin
                            // Greater with every bit already set cannot happen
                            // for a consistent comparator.
                            error_d  = 1'b1;
                            result_d = '0;
                        end
                    end
                end
            end

            S_DONE: begin
                trial_d = '0;
                state_d = S_IDLE;
            end

            default: begin
                // IDLE, and the unused encoding recovers through here.
                trial_d = '0;
                state_d = S_IDLE;
                if (start) begin
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    pos_d   = PW'(WIDTH - 1);
                    error_d = 1'b0;
                    state_d = S_TRY;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            pos_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            pos_q    <= pos_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = (state_q == S_TRY);
    assign done   = (state_q == S_DONE);
    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: a real comparator closes the loop, with a bypass
// mux for injecting faulty responses. Expected outcomes are queued when a
// search is launched and compared when the controller reports done.
module tb_sar_search_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic       byp_en, byp_eq, byp_gt, byp_lt;
    logic       c_eq, c_gt, c_lt;
    logic       cmp_equal, cmp_greater, cmp_lesser;
    logic [3:0] trial;
    logic       busy, done, error;
    logic [3:0] result;

    always #5 clk = ~clk;

    comparator_4bit u_cmp (
        .a       (target),
        .b       (trial),
        .equal   (c_eq),
        .greater (c_gt),
        .lesser  (c_lt)
    );

    assign cmp_equal   = byp_en ? byp_eq : c_eq;
    assign cmp_greater = byp_en ? byp_gt : c_gt;
    assign cmp_lesser  = byp_en ? byp_lt : c_lt;

    sar_search_4bit #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmp_equal   (cmp_equal),
        .cmp_greater (cmp_greater),
        .cmp_lesser  (cmp_lesser),
        .trial       (trial),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .result      (result)
    );

    typedef struct {
        logic [3:0] res;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] trial_log[$];
    int         n_vec = 0;
    int         n_bad = 0;

    // Reference latency: the search ends once the lowest set bit of the target
    // has been tried (equal), or after all four trials for target 0.
    function automatic int exp_lat(input logic [3:0] t);
        for (int j = 0; j < 4; j++) begin
            if (t[j]) return (4 - j) + 1;
        end
        return 5;
    endfunction

    // Launches one search and watches it to completion.
    // fmode 0: true comparator; 1: all responses low during cycle fcycle;
    // 2: "greater" forced on every cycle.
    task automatic run_search(input logic [3:0] tgt, input int fmode, input int fcycle,
                              input logic hold_start, output logic [3:0] res,
                              output logic err, output int lat);
        int cyc;
        bit seen;
        trial_log.delete();
        res = 'x;
        err = 1'bx;
        lat = -1;
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        byp_en = 1'b0;
        @(negedge clk);
        start = hold_start;
        cyc   = 1;
        seen  = 0;
        while (!seen && cyc <= 12) begin
            if (fmode == 1 && cyc == fcycle) {byp_en, byp_eq, byp_gt, byp_lt} = 4'b1000;
            else if (fmode == 2)             {byp_en, byp_eq, byp_gt, byp_lt} = 4'b1010;
            else                             byp_en = 1'b0;
            n_vec++;
            if ((done & busy) !== 1'b0) begin
                n_bad++;
                $display("FAIL done_busy_overlap: cycle %0d done=%b busy=%b, required not both high", cyc, done, busy);
            end
            if (done === 1'b1) begin
                seen = 1;
                res  = result;
                err  = error;
                lat  = cyc;
            end else begin
                if (busy === 1'b1) trial_log.push_back(trial);
                cyc++;
                @(negedge clk);
            end
        end
        start  = 1'b0;
        byp_en = 1'b0;
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL search_timeout: target %0d no done within 12 cycles, required done", tgt);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        target = 4'd0;
        byp_en = 1'b0;
        byp_eq = 1'b0;
        byp_gt = 1'b0;
        byp_lt = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({trial, busy, done, error, result} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_state: trial=%b busy=%b done=%b error=%b result=%b, required all 0",
                     trial, busy, done, error, result);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({trial, busy, done} !== 6'd0) begin
            n_bad++;
            $display("FAIL idle_after_reset: trial=%b busy=%b done=%b, required 0", trial, busy, done);
        end
        $display("test_reset: outputs after reset trial=%b busy=%b done=%b", trial, busy, done);
    endtask

    task automatic test_first_trial_equal();
        logic [3:0] r; logic e; int l; exp_t ex;
        exp_q.push_back('{res: 4'd8, err: 1'b0, lat: 2});
        run_search(4'd8, 0, 0, 1'b0, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL first_trial_equal: result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     r, e, l, ex.res, ex.err, ex.lat);
        end
        n_vec++;
        if (trial_log.size() != 1 || trial_log[0] !== 4'b1000) begin
            n_bad++;
            $display("FAIL first_trial_value: %0d trials logged, first=%b, required one trial 1000",
                     trial_log.size(), (trial_log.size() > 0) ? trial_log[0] : 4'bx);
        end
        $display("test_first_trial_equal: target 8 result=%0d latency=%0d", r, l);
    endtask

    task automatic test_sequence(input logic [3:0] tgt, input logic [15:0] seq);
        logic [3:0] r; logic e; int l; exp_t ex; logic [3:0] want;
        exp_q.push_back('{res: tgt, err: 1'b0, lat: 5});
        run_search(tgt, 0, 0, 1'b0, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL sequence_result: target %0d result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     tgt, r, e, l, ex.res, ex.err, ex.lat);
        end
        for (int i = 0; i < 4; i++) begin
            want = seq[15 - 4*i -: 4];
            n_vec++;
            if (trial_log.size() != 4 || trial_log[i] !== want) begin
                n_bad++;
                $display("FAIL trial_seq: target %0d trial %0d = %b (%0d logged), required %b",
                         tgt, i + 1, (i < trial_log.size()) ? trial_log[i] : 4'bx, trial_log.size(), want);
            end
        end
        $display("test_sequence: target %0d result=%0d latency=%0d trials=%0d", tgt, r, l, trial_log.size());
    endtask

    task automatic test_sweep();
        logic [3:0] r; logic e; int l; exp_t ex;
        for (int t = 0; t < 16; t++) begin
            exp_q.push_back('{res: 4'(t), err: 1'b0, lat: exp_lat(4'(t))});
            run_search(4'(t), 0, 0, 1'b0, r, e, l);
            ex = exp_q.pop_front();
            n_vec++;
            if (r !== ex.res || e !== ex.err || l !== ex.lat || l > 5) begin
                n_bad++;
                $display("FAIL sweep: target %0d result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                         t, r, e, l, ex.res, ex.err, ex.lat);
            end
            $display("test_sweep: target %0d result=%0d error=%b latency=%0d", t, r, e, l);
        end
    endtask

    task automatic test_fault_silent();
        logic [3:0] r; logic e; int l; exp_t ex;
        exp_q.push_back('{res: 4'd0, err: 1'b1, lat: 3});
        run_search(4'd5, 1, 2, 1'b0, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL fault_silent: result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     r, e, l, ex.res, ex.err, ex.lat);
        end
        $display("test_fault_silent: result=%0d error=%b latency=%0d", r, e, l);
    endtask

    task automatic test_fault_greater();
        logic [3:0] r; logic e; int l; exp_t ex;
        exp_q.push_back('{res: 4'd0, err: 1'b1, lat: 5});
        run_search(4'd3, 2, 0, 1'b0, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL fault_greater: result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     r, e, l, ex.res, ex.err, ex.lat);
        end
        // Error must stay visible after the done pulse until a new start.
        @(negedge clk);
        n_vec++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL error_hold: error=%b in idle after faulty search, required 1", error);
        end
        $display("test_fault_greater: result=%0d error=%b latency=%0d", r, e, l);
    endtask

    task automatic test_reset_mid_search();
        logic [3:0] r; logic e; int l; exp_t ex;
        // Leave a non-zero result behind so the reset clearing it is visible.
        exp_q.push_back('{res: 4'd15, err: 1'b0, lat: 5});
        run_search(4'd15, 0, 0, 1'b0, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL pre_reset_search: result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     r, e, l, ex.res, ex.err, ex.lat);
        end
        @(negedge clk);
        target = 4'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_try: busy=%b at cycle 2, required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({trial, busy, done, error, result} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_mid_search: trial=%b busy=%b done=%b error=%b result=%b, required all 0",
                     trial, busy, done, error, result);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_mid_reset: busy=%b done=%b, required 00", busy, done);
        end
        $display("test_reset_mid_search: outputs after reset result=%0d busy=%b", result, busy);
    endtask

    task automatic test_start_with_rst();
        @(negedge clk);
        target = 4'd6;
        rst    = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_vec++;
        if ({busy, trial} !== 5'd0) begin
            n_bad++;
            $display("FAIL start_with_rst: busy=%b trial=%b, required idle with trial 0", busy, trial);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_with_rst_later: busy=%b done=%b, required 00", busy, done);
        end
        $display("test_start_with_rst: busy=%b trial=%b", busy, trial);
    endtask

    task automatic test_start_held_in_try();
        logic [3:0] r; logic e; int l; exp_t ex;
        exp_q.push_back('{res: 4'd0, err: 1'b0, lat: 5});
        run_search(4'd0, 0, 0, 1'b1, r, e, l);
        ex = exp_q.pop_front();
        n_vec++;
        if (r !== ex.res || e !== ex.err || l !== ex.lat) begin
            n_bad++;
            $display("FAIL start_held_in_try: result=%0d error=%b latency=%0d, required %0d/%b/%0d",
                     r, e, l, ex.res, ex.err, ex.lat);
        end
        $display("test_start_held_in_try: result=%0d latency=%0d", r, l);
    endtask

    task automatic test_back_to_back(input logic [3:0] tgt);
        int period; int cyc; int prev; int seen; exp_t ex;
        period = exp_lat(tgt) + 1;
        exp_q.push_back('{res: tgt, err: 1'b0, lat: period - 1});
        exp_q.push_back('{res: tgt, err: 1'b0, lat: period});
        exp_q.push_back('{res: tgt, err: 1'b0, lat: period});
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        cyc  = 0;
        prev = 0;
        seen = 0;
        while (seen < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                ex = exp_q.pop_front();
                seen++;
                n_vec++;
                if (result !== ex.res || error !== ex.err || (cyc - prev) !== ex.lat) begin
                    n_bad++;
                    $display("FAIL back_to_back: target %0d search %0d result=%0d error=%b interval=%0d, required %0d/%b/%0d",
                             tgt, seen, result, error, cyc - prev, ex.res, ex.err, ex.lat);
                end
                $display("test_back_to_back: target %0d search %0d interval=%0d result=%0d",
                         tgt, seen, cyc - prev, result);
                prev = cyc;
            end
        end
        start = 1'b0;
        if (seen < 3) begin
            n_vec++;
            n_bad++;
            $display("FAIL back_to_back_timeout: target %0d only %0d done pulses, required 3", tgt, seen);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_trial_equal();
        test_sequence(4'd0,  16'b1000_0100_0010_0001);
        test_sequence(4'd15, 16'b1000_1100_1110_1111);
        test_fault_silent();
        test_fault_greater();
        test_sweep();
        test_reset_mid_search();
        test_start_with_rst();
        test_start_held_in_try();
        test_back_to_back(4'd8);
        test_back_to_back(4'd0);
        test_back_to_back(4'd6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
